// File: rtl/led_ws2812_tx.sv
// WS2812-style single-wire LED transmitter: latches an RGB colour, reorders it to GRB and
// sends it as pulse-width-coded bits to NUM_LEDS LEDs, followed by a low latch gap.
`timescale 1ns/1ps
module led_ws2812_tx #(
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int RESET_CYC = 3000,
    parameter int NUM_LEDS  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] cor_led,
    input  logic        iniciar,
    output logic        ocupado,
    output logic        pronto,
    output logic        dout
);

    localparam int CYC_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CYC_W-1:0] T0H_LAST   = CYC_W'(T0H_CYC - 1);
    localparam logic [CYC_W-1:0] T1H_LAST   = CYC_W'(T1H_CYC - 1);
    localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] RESET_LAST = CYC_W'(RESET_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_ZERO   = CYC_W'(0);
    localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
    localparam logic [LED_W-1:0] LED_LAST   = LED_W'(NUM_LEDS - 1);
    localparam logic [LED_W-1:0] LED_ZERO   = LED_W'(0);
    localparam logic [LED_W-1:0] LED_ONE    = LED_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BIT_HIGH = 2'd1,
        BIT_LOW  = 2'd2,
        LATCH    = 2'd3
    } state_t;

    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    state_t           state, state_nxt;
    logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
    logic [4:0]       bit_cnt, bit_nxt;
    logic [LED_W-1:0] led_cnt, led_nxt;
    logic [23:0]      shreg, shreg_nxt;
    logic [23:0]      grb, grb_nxt;
    logic             pronto_nxt;
    logic             dout_nxt;
    logic             ocupado_nxt;
    logic [CYC_W-1:0] high_last;

    // Next-state, counter and output decode for the frame sequencer
    always_comb begin
        state_nxt  = state;
        cyc_nxt    = cyc_cnt;
        bit_nxt    = bit_cnt;
        led_nxt    = led_cnt;
        shreg_nxt  = shreg;
        grb_nxt    = grb;
        pronto_nxt = 1'b0;
        high_last  = shreg[23] ? T1H_LAST : T0H_LAST;

        case (state)
            IDLE: begin
                // The pronto cycle itself is still IDLE, so a start there must be refused
                if (iniciar && !pronto) begin
                    shreg_nxt = rgb_to_grb(cor_led);
                    grb_nxt   = rgb_to_grb(cor_led);
                    cyc_nxt   = CYC_ZERO;
                    bit_nxt   = 5'd0;
                    led_nxt   = LED_ZERO;
                    state_nxt = BIT_HIGH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BIT_HIGH: begin
                cyc_nxt = cyc_cnt + CYC_ONE;
                if (cyc_cnt == high_last) begin
                    state_nxt = BIT_LOW;
                end else begin
                    state_nxt = BIT_HIGH;
                end
            end
            BIT_LOW: begin
                if (cyc_cnt == BIT_LAST) begin
                    cyc_nxt = CYC_ZERO;
                    if (bit_cnt != 5'd23) begin
                        shreg_nxt = {shreg[22:0], 1'b0};
                        bit_nxt   = bit_cnt + 5'd1;
                        state_nxt = BIT_HIGH;
                    end else if (led_cnt != LED_LAST) begin
                        shreg_nxt = grb;
                        bit_nxt   = 5'd0;
                        led_nxt   = led_cnt + LED_ONE;
                        state_nxt = BIT_HIGH;
                    end else begin
                        state_nxt = LATCH;
                    end
                end else begin
                    cyc_nxt   = cyc_cnt + CYC_ONE;
                    state_nxt = BIT_LOW;
                end
            end
            LATCH: begin
                if (cyc_cnt == RESET_LAST) begin
                    cyc_nxt    = CYC_ZERO;
                    pronto_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cyc_nxt   = cyc_cnt + CYC_ONE;
                    state_nxt = LATCH;
                end
            end
            default: begin
                cyc_nxt   = CYC_ZERO;
                state_nxt = IDLE;
            end
        endcase

        dout_nxt    = (state_nxt == BIT_HIGH);
        ocupado_nxt = (state_nxt != IDLE);
    end

    // State, datapath and registered outputs with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            cyc_cnt <= CYC_ZERO;
            bit_cnt <= 5'd0;
            led_cnt <= LED_ZERO;
            shreg   <= 24'd0;
            grb     <= 24'd0;
            dout    <= 1'b0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            led_cnt <= led_nxt;
            shreg   <= shreg_nxt;
            grb     <= grb_nxt;
            dout    <= dout_nxt;
            ocupado <= ocupado_nxt;
            pronto  <= pronto_nxt;
        end
    end

endmodule

// File: tb/tb_led_ws2812_tx.sv
// Directed self-checking bench for led_ws2812_tx with small timing parameters.
`timescale 1ns/1ps
module tb_led_ws2812_tx;

    localparam int T0H        = 2;
    localparam int T1H        = 4;
    localparam int BITC       = 6;
    localparam int RSTC       = 10;
    localparam int NL         = 2;
    localparam int LED_LEN    = 24 * BITC;
    localparam int FRAME_BITS = LED_LEN * NL;
    localparam int FRAME_LEN  = FRAME_BITS + RSTC;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        iniciar;
    logic [23:0] cor_led;
    logic        ocupado;
    logic        pronto;
    logic        dout;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    led_ws2812_tx #(
        .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RESET_CYC(RSTC), .NUM_LEDS(NL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cor_led(cor_led), .iniciar(iniciar),
        .ocupado(ocupado), .pronto(pronto), .dout(dout)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_dout(input logic [23:0] grb, input int k);
        int   b;
        int   ph;
        logic v;
        b  = (k % LED_LEN) / BITC;
        ph = k % BITC;
        v  = grb[23 - b];
        return (ph < (v ? T1H : T0H));
    endfunction

    // Starts at the sample of the first high cycle, ends at the pronto sample.
    task automatic check_stream(input logic [23:0] grb, input bit poke);
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k < FRAME_BITS) check("dout", 32'(dout), 32'(exp_dout(grb, k)));
            else                check("latch_dout", 32'(dout), 32'd0);
            check("ocupado", 32'(ocupado), 32'd1);
            check("pronto_early", 32'(pronto), 32'd0);
            if (poke && k == 50) begin
                cor_led = 24'h123456;
                iniciar = 1'b1;
            end else begin
                iniciar = 1'b0;
            end
            step();
        end
        check("pronto", 32'(pronto), 32'd1);
        check("ocupado_end", 32'(ocupado), 32'd0);
        check("dout_end", 32'(dout), 32'd0);
    endtask

    initial begin
        int          seen_pronto;
        int          seen_busy;
        int          seen_high;
        logic [23:0] c;
        logic [23:0] g;

        reset_n = 1'b0;
        iniciar = 1'b1;
        cor_led = 24'hFF0080;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_dout", 32'(dout), 32'd0);
            check("rst_ocupado", 32'(ocupado), 32'd0);
            check("rst_pronto", 32'(pronto), 32'd0);
        end
        reset_n = 1'b1;
        iniciar = 1'b0;
        step();
        check("idle_ocupado", 32'(ocupado), 32'd0);

        // Single frame FF0080 -> GRB 00FF80, one-cycle start latency
        cor_led = 24'hFF0080;
        iniciar = 1'b1;
        step();
        check_stream(24'h00FF80, 1'b0);

        // Start held from the pronto cycle: refused there, accepted one cycle later
        cor_led = 24'h000001;
        iniciar = 1'b1;
        step();
        check("pronto_cycle_ignored", 32'(ocupado), 32'd0);
        check("pronto_one_cycle", 32'(pronto), 32'd0);
        check("gap_dout", 32'(dout), 32'd0);
        step();
        check_stream(24'h000001, 1'b1);

        // Busy request must not produce a second frame
        iniciar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("no_second_pronto", 32'(pronto), 32'd0);
            check("no_second_frame", 32'(ocupado), 32'd0);
        end

        // Reset during bit 10 of LED 1
        cor_led = 24'hFFFFFF;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int i = 0; i < 62; i++) step();
        check("pre_reset_busy", 32'(ocupado), 32'd1);
        reset_n = 1'b0;
        step();
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_ocupado", 32'(ocupado), 32'd0);
        reset_n = 1'b1;
        seen_pronto = 0;
        seen_busy   = 0;
        seen_high   = 0;
        for (int i = 0; i < FRAME_LEN + 20; i++) begin
            step();
            if (pronto !== 1'b0)  seen_pronto++;
            if (ocupado !== 1'b0) seen_busy++;
            if (dout !== 1'b0)    seen_high++;
        end
        check("abort_no_pronto", 32'(seen_pronto), 32'd0);
        check("abort_no_busy", 32'(seen_busy), 32'd0);
        check("abort_no_dout", 32'(seen_high), 32'd0);

        cor_led = 24'hA5C30F;
        iniciar = 1'b1;
        step();
        check_stream(24'hC3A50F, 1'b0);

        // Pulse-width and bit-period measurement over random colours
        for (int r = 0; r < 2; r++) begin
            int   rise;
            int   rises;
            logic prev;
            iniciar = 1'b0;
            step();
            c = 24'($urandom);
            g = {c[15:8], c[23:16], c[7:0]};
            cor_led = c;
            iniciar = 1'b1;
            step();
            iniciar = 1'b0;
            rise  = -1;
            rises = 0;
            prev  = 1'b0;
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (dout && !prev) begin
                    if (rise >= 0) check("bit_period", 32'(k - rise), 32'(BITC));
                    rise = k;
                    rises++;
                end
                if (!dout && prev) begin
                    check("hi_width_legal", 32'(((k - rise) == T0H) || ((k - rise) == T1H)), 32'd1);
                    check("hi_width_bit", 32'(k - rise), 32'(exp_dout(g, rise + T0H) ? T1H : T0H));
                end
                prev = dout;
                step();
            end
            check("pulse_count", 32'(rises), 32'(24 * NL));
            check("rand_pronto", 32'(pronto), 32'd1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
